// File: rtl/row_assembler.sv
// row_assembler: packs COLS raster pixels into one row word and hands rows out with valid/ack.
module row_assembler #(
    parameter int COLS  = 256,
    parameter int ROWS  = 256,
    parameter int WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [3*WIDTH-1:0]      pix_in,
    input  logic                    pix_valid,
    input  logic                    pix_sof,
    output logic                    pix_ready,
    output logic [COLS*3*WIDTH-1:0] row_out,
    output logic                    row_valid,
    input  logic                    row_ack,
    output logic                    row_first,
    output logic                    row_last,
    output logic                    sof_err
);
    localparam int PW = 3 * WIDTH;
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;

    logic [COLS*PW-1:0] fill;
    logic [CW-1:0]      col;
    logic [CW-1:0]      slot;
    logic [RW-1:0]      row;
    logic               stage_full;
    logic               accept;
    logic               transfer;
    logic               slot_last;

    always_comb begin
        pix_ready = !stage_full && !RST;
        accept    = pix_valid && pix_ready;
        transfer  = stage_full && (!row_valid || row_ack);
        slot      = pix_sof ? '0 : col;
        slot_last = slot == CW'(COLS - 1);
    end

    // A frame start always lands in slot 0, discarding any partial row.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fill       <= '0;
            col        <= '0;
            row        <= '0;
            stage_full <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            sof_err <= accept && pix_sof && col != '0;
            if (accept) begin
                for (int j = 0; j < COLS; j++)
                    if (slot == CW'(j))
                        fill[COLS*PW-1-PW*j -: PW] <= pix_in;
                col        <= slot_last ? '0 : slot + 1'b1;
                stage_full <= slot_last;
                if (pix_sof)
                    row <= '0;
            end else if (transfer) begin
                stage_full <= 1'b0;
                row        <= row == RW'(ROWS - 1) ? '0 : row + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_out   <= '0;
            row_valid <= 1'b0;
            row_first <= 1'b0;
            row_last  <= 1'b0;
        end else if (transfer) begin
            row_out   <= fill;
            row_valid <= 1'b1;
            row_first <= row == '0;
            row_last  <= row == RW'(ROWS - 1);
        end else if (row_ack && row_valid) begin
            row_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_row_assembler.sv
// tb_row_assembler: directed checks of row packing, flags, backpressure, sof errors and async reset.
module tb_row_assembler;
    logic        CLK;
    logic        RST;
    logic [23:0] pix_in;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic [95:0] row_out;
    logic        row_valid;
    logic        row_ack;
    logic        row_first;
    logic        row_last;
    logic        sof_err;
    int          checks = 0;
    int          errors = 0;
    logic [23:0] px [4];

    row_assembler #(.COLS(4), .ROWS(3), .WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_ready(pix_ready), .row_out(row_out), .row_valid(row_valid), .row_ack(row_ack),
        .row_first(row_first), .row_last(row_last), .sof_err(sof_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one pixel starting just after an edge; returns 1ns after its accept edge.
    task automatic send(input logic [23:0] p, input logic sof);
        int n = 0;
        pix_in    = p;
        pix_sof   = sof;
        pix_valid = 1'b1;
        while (!pix_ready && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("accept_timeout", 96'(n < 50), 96'd1);
        @(posedge CLK);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_in    = 24'hxxxxxx;
    endtask

    task automatic send_row(input logic [23:0] base, input logic sof);
        for (int k = 0; k < 4; k++) begin
            px[k] = base + 24'(k);
            send(px[k], sof && k == 0);
        end
    endtask

    function automatic logic [95:0] expect_row();
        return {px[0], px[1], px[2], px[3]};
    endfunction

    task automatic ack_one();
        row_ack = 1'b1;
        @(posedge CLK);
        #1;
        row_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; pix_in = '0; pix_valid = 1'b0; pix_sof = 1'b0; row_ack = 1'b0;
        #12;
        check("rst_ready", 96'(pix_ready), 96'd0);
        check("rst_valid", 96'(row_valid), 96'd0);
        check("rst_row_out", row_out, 96'd0);
        check("rst_flags", {94'd0, row_first, row_last}, 96'd0);
        check("rst_sof_err", 96'(sof_err), 96'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // Row 0 with hand-computed packing and one-cycle transfer latency
        px[0] = 24'h010203; px[1] = 24'h040506; px[2] = 24'h070809; px[3] = 24'h0A0B0C;
        send(px[0], 1'b1);
        check("sof_clean", 96'(sof_err), 96'd0);
        for (int k = 1; k < 4; k++) send(px[k], 1'b0);
        check("lat_valid_low", 96'(row_valid), 96'd0);
        check("lat_ready_low", 96'(pix_ready), 96'd0);
        tick();
        check("row0_valid", 96'(row_valid), 96'd1);
        check("row0_out", row_out, 96'h0102030405060708090A0B0C);
        check("row0_flags", {94'd0, row_first, row_last}, 96'b10);
        check("row0_ready", 96'(pix_ready), 96'd1);
        ack_one();
        check("ack_clears", 96'(row_valid), 96'd0);
        check("ack_keeps_out", row_out, 96'h0102030405060708090A0B0C);
        ack_one();
        check("ack_ignored", 96'(row_valid), 96'd0);

        // Rows 1, 2, then wrap to row 0 without sof
        send_row(24'h100000, 1'b0);
        tick();
        check("row1_out", row_out, expect_row());
        check("row1_flags", {94'd0, row_first, row_last}, 96'b00);
        ack_one();
        send_row(24'h200000, 1'b0);
        tick();
        check("row2_out", row_out, expect_row());
        check("row2_flags", {94'd0, row_first, row_last}, 96'b01);
        ack_one();
        send_row(24'h300000, 1'b0);
        tick();
        check("wrap_out", row_out, expect_row());
        check("wrap_flags", {94'd0, row_first, row_last}, 96'b10);

        // Backpressure: wrap row stays held while the next row fills
        begin
            logic [95:0] held;
            held = expect_row();
            send_row(24'h400000, 1'b0);
            repeat (3) tick();
            check("bp_ready", 96'(pix_ready), 96'd0);
            check("bp_valid", 96'(row_valid), 96'd1);
            check("bp_held_out", row_out, held);
            ack_one();
            check("bp_load_valid", 96'(row_valid), 96'd1);
            check("bp_load_out", row_out, expect_row());
            check("bp_load_flags", {94'd0, row_first, row_last}, 96'b00);
            check("bp_ready_back", 96'(pix_ready), 96'd1);
            ack_one();
        end

        // Mid-row sof discards the partial row
        send(24'h555555, 1'b0);
        send(24'h666666, 1'b0);
        send(24'hFFFFFF, 1'b1);
        check("sof_err_pulse", 96'(sof_err), 96'd1);
        px[0] = 24'hFFFFFF; px[1] = 24'hA1A2A3; px[2] = 24'hB1B2B3; px[3] = 24'hC1C2C3;
        send(px[1], 1'b0);
        check("sof_err_once", 96'(sof_err), 96'd0);
        send(px[2], 1'b0);
        send(px[3], 1'b0);
        tick();
        check("sof_row_out", row_out, expect_row());
        check("sof_row_first", 96'(row_first), 96'd1);

        // Async reset between edges with a held row and a partial row
        send(24'h777777, 1'b0);
        send(24'h888888, 1'b0);
        send(24'h999999, 1'b0);
        check("pre_rst_valid", 96'(row_valid), 96'd1);
        #2;
        RST = 1'b1;
        #1;
        check("arst_ready", 96'(pix_ready), 96'd0);
        check("arst_valid", 96'(row_valid), 96'd0);
        check("arst_out", row_out, 96'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        send_row(24'h0C0D0E, 1'b0);
        tick();
        check("post_rst_out", row_out, expect_row());
        check("post_rst_flags", {94'd0, row_first, row_last}, 96'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
